// File: rtl/dual_beam_trig_scaler_if.sv
// Scaler result handshake between the trigger scaler and the readout/control side.
interface dual_beam_trig_scaler_if #(
  parameter int unsigned SCALER_BITS = 16
) ();

  logic                       scal_valid_o;
  logic                       scal_ready_i;
  logic [2*SCALER_BITS-1:0]   scal_data_o;
  logic                       scal_overrun_o;

  // Producer side: the scaler drives valid/data/overrun and samples ready.
  modport master (
    output scal_valid_o,
    output scal_data_o,
    output scal_overrun_o,
    input  scal_ready_i
  );

  // Consumer side: readout samples the result and drives ready.
  modport slave (
    input  scal_valid_o,
    input  scal_data_o,
    input  scal_overrun_o,
    output scal_ready_i
  );

endinterface

// File: rtl/dual_beam_trig_scaler.sv
// Per-beam trigger holdoff qualification and gated trigger scaler with a
// single-entry valid/ready result register and sticky overrun flag.
module dual_beam_trig_scaler #(
  parameter int unsigned SCALER_BITS  = 16,
  parameter int unsigned HOLDOFF_BITS = 8,
  parameter int unsigned PERIOD_BITS  = 24
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [1:0]               trigger_i,
  input  logic [HOLDOFF_BITS-1:0]  holdoff_i,
  input  logic [PERIOD_BITS-1:0]   period_i,
  input  logic                     enable_i,
  output logic [1:0]               trig_o,
  dual_beam_trig_scaler_if.master  scal
);

  localparam int unsigned DATA_BITS = 2 * SCALER_BITS;
  localparam logic [SCALER_BITS-1:0] SCAL_MAX = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  state_e                              state_q, state_d;
  logic [1:0]                          trig_q, trig_d;
  logic [1:0]                          trig_o_q, trig_o_d;
  logic [1:0][HOLDOFF_BITS-1:0]        hold_cnt_q, hold_cnt_d;
  logic [PERIOD_BITS-1:0]              per_cnt_q, per_cnt_d;
  logic [1:0][SCALER_BITS-1:0]         acc_q, acc_d;
  logic                                valid_q, valid_d;
  logic [DATA_BITS-1:0]                data_q, data_d;
  logic                                ovr_q, ovr_d;

  logic [1:0][SCALER_BITS-1:0]         sum_c;
  logic [PERIOD_BITS-1:0]              period_eff_c;
  logic                                gate_end_c;

  // A zero gate length is treated as a one-clock gate.
  assign period_eff_c = (period_i == '0) ? PERIOD_BITS'(1) : period_i;

  // Holdoff qualification: pass a trigger only when the beam's holdoff has expired.
  always_comb begin
    trig_d     = trigger_i;
    trig_o_d   = '0;
    hold_cnt_d = hold_cnt_q;
    for (int b = 0; b < 2; b++) begin
      if (trig_q[b] && (hold_cnt_q[b] == '0)) begin
        trig_o_d[b]   = 1'b1;
        hold_cnt_d[b] = holdoff_i;
      end else if (hold_cnt_q[b] != '0) begin
        hold_cnt_d[b] = hold_cnt_q[b] - HOLDOFF_BITS'(1);
      end
    end
  end

  // Saturating running sum including this cycle's qualified pulse.
  always_comb begin
    sum_c = acc_q;
    for (int b = 0; b < 2; b++) begin
      if (trig_o_q[b] && (acc_q[b] != SCAL_MAX)) begin
        sum_c[b] = acc_q[b] + SCALER_BITS'(1);
      end
    end
  end

  // Gate sequencing and result hand-off into the output register.
  always_comb begin
    state_d    = state_q;
    per_cnt_d  = per_cnt_q;
    acc_d      = acc_q;
    valid_d    = valid_q;
    data_d     = data_q;
    ovr_d      = ovr_q;
    gate_end_c = 1'b0;

    case (state_q)
      IDLE: begin
        acc_d = '0;
        if (enable_i) begin
          state_d   = COUNT;
          per_cnt_d = period_eff_c;
          ovr_d     = 1'b0;
        end
      end
      COUNT: begin
        if (!enable_i) begin
          state_d = IDLE;
          acc_d   = '0;
        end else if (per_cnt_q == PERIOD_BITS'(1)) begin
          gate_end_c = 1'b1;
          per_cnt_d  = period_eff_c;
          acc_d      = '0;
        end else begin
          per_cnt_d = per_cnt_q - PERIOD_BITS'(1);
          acc_d     = sum_c;
        end
      end
      default: state_d = IDLE;
    endcase

    if (gate_end_c) begin
      if (!valid_q || scal.scal_ready_i) begin
        valid_d = 1'b1;
        data_d  = {sum_c[1], sum_c[0]};
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && scal.scal_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // State register, asynchronously cleared.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      trig_q     <= '0;
      trig_o_q   <= '0;
      hold_cnt_q <= '0;
      per_cnt_q  <= '0;
      acc_q      <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      trig_q     <= trig_d;
      trig_o_q   <= trig_o_d;
      hold_cnt_q <= hold_cnt_d;
      per_cnt_q  <= per_cnt_d;
      acc_q      <= acc_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      ovr_q      <= ovr_d;
    end
  end

  assign trig_o              = trig_o_q;
  assign scal.scal_valid_o   = valid_q;
  assign scal.scal_data_o    = data_q;
  assign scal.scal_overrun_o = ovr_q;

endmodule

// File: doc/dual_beam_trig_scaler.md
Name: dual_beam_trig_scaler

Overview:
Downstream consumer of the dual-beam threshold stage's 2-bit per-clock trigger output. For each beam it:
- applies a programmable holdoff to produce qualified single-cycle trigger pulses;
- counts qualified triggers over a programmable gate period;
- hands the per-beam counts to the readout/control side through a valid/ready register.

Parameters:
SCALER_BITS, 16, per-beam scaler counter width (saturating)
HOLDOFF_BITS, 8, holdoff counter width
PERIOD_BITS, 24, gate period counter width (clock cycles)

Ports:
clk_i  in  1  beam-clock domain clock (375 MHz)
rst_n_i  in  1  asynchronous, active-low reset
trigger_i  in  2  raw per-clock beam triggers, bit0 = beam A, bit1 = beam B
holdoff_i  in  HOLDOFF_BITS  holdoff length in clocks after a qualified trigger
period_i  in  PERIOD_BITS  gate length in clocks
enable_i  in  1  scaler run enable (level)
trig_o  out  2  qualified trigger pulses
scal_valid_o  out  1  scaler result valid
scal_ready_i  in  1  consumer accepts result
scal_data_o  out  2*SCALER_BITS  {beamB_count, beamA_count}
scal_overrun_o  out  1  sticky: a gate result was dropped

Behaviour:
Interface:
- One clock, clk_i. Reset rst_n_i is asynchronous and active-low.
- While rst_n_i is low, all registers are 0 and all outputs read 0. FSM is in IDLE.

Holdoff path (per beam b, independent):
- trigger_i is registered once into trig_q.
- If trig_q[b]=1 and hold_cnt[b]=0: trig_o[b]<=1 next clock and hold_cnt[b]<=holdoff_i.
- Otherwise trig_o[b]<=0, and hold_cnt[b] decrements if nonzero.
- Latency from trigger_i to trig_o is exactly 2 clocks.
- holdoff_i=0: every asserted cycle passes.
- holdoff_i=N: minimum spacing between trig_o pulses is N+1 clocks.
- holdoff_i is sampled only at reload, so a change mid-holdoff takes effect at the next qualified trigger.
- The holdoff path runs regardless of enable_i.

Scaler FSM, states IDLE and COUNT:
- IDLE:
  - Accumulators held at 0.
  - On enable_i=1: go to COUNT, load per_cnt with max(period_i,1), clear acc[1:0], clear scal_overrun_o.
- COUNT, each clock:
  - acc[b] += trig_o[b], saturating at 2^SCALER_BITS-1.
  - per_cnt decrements.
- End of gate (per_cnt==1):
  - The final sum, including the current trig_o, is offered to the output register.
  - per_cnt reloads from period_i with 0 treated as 1, and acc clears.
  - The next gate starts on the following clock with no dead cycle.
- enable_i=0 in COUNT: return to IDLE next clock. Partial gate counts are discarded and no result is produced. A pending result already in the output register is kept.

Output handshake:
- A result transfers when (!scal_valid_o || scal_ready_i): scal_data_o<=sums, scal_valid_o<=1.
- If the buffer is full and not being accepted: the result is dropped and scal_overrun_o<=1 (sticky until the next IDLE->COUNT).
- Valid high and ready high with no new result: valid<=0.
- Valid high, ready high and a new result in the same cycle: new data loads and valid stays 1.
- scal_data_o is stable while valid=1 and ready=0.

Boundaries:
- Saturated counts stay at all-ones until the gate ends.
- period_i=1 produces a result every clock.
- Reset asserted mid-gate clears everything immediately, asynchronously.

Test Plan:
1. Reset, holdoff_i=0, trigger_i=2'b01 for a single clock at cycle 10 -> trig_o=2'b01 only at cycle 12, trig_o=0 elsewhere.
2. holdoff_i=3, trigger_i[1] held high for 12 clocks -> trig_o[1] pulses at offsets 0,4,8 after the 2-clock latency (3 pulses). trig_o[0] stays 0.
3. enable_i=1, period_i=100, holdoff_i=0, trigger_i=2'b11 every 4th clock, scal_ready_i=1 -> scal_valid_o pulses once per 100 clocks with scal_data_o={16'd25,16'd25}. scal_overrun_o=0.
4. As in scenario 3 but scal_ready_i=0 -> first result is held stable. At the second gate end scal_overrun_o=1 and scal_data_o is unchanged. Raise ready -> valid drops next clock.
5. SCALER_BITS=16, period_i=70000, trigger_i=2'b11 continuously, holdoff_i=0 -> scal_data_o={16'hFFFF,16'hFFFF}.
6. Drop enable_i at clock 50 of a 100-clock gate, then pulse rst_n_i low mid-second-gate -> no result from the aborted gate. Reset asynchronously zeros trig_o, scal_valid_o, scal_overrun_o and scal_data_o.
